// File: rtl/bus_term_stim_seq_if.sv
// Entry push channel into the bus-term stimulus sequencer.
// The master offers {code, exp, hold} entries; the slave answers with s_ready.
interface bus_term_stim_seq_if #(
    parameter int NBIT = 2,
    parameter int HW   = 4
);
    logic            s_valid;
    logic            s_ready;
    logic [NBIT-1:0] s_code;
    logic            s_exp;
    logic [HW-1:0]   s_hold;

    modport master (output s_valid, s_code, s_exp, s_hold, input s_ready);
    modport slave  (input s_valid, s_code, s_exp, s_hold, output s_ready);
endinterface

// File: rtl/bus_term_stim_seq.sv
// Stimulus sequencer for the 2-bit bus-terminated cell: queues entries, replays codes, checks obs.
// Optional first-mismatch log enabled by macro BUS_TERM_STIM_MISMATCH_LOG_EN.
module bus_term_stim_seq #(
    parameter int              NBIT      = 2,
    parameter int              DEPTH     = 8,
    parameter int              HW        = 4,
    parameter int              EW        = 8,
    parameter logic [NBIT-1:0] IDLE_CODE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    bus_term_stim_seq_if.slave   s,
    output logic [NBIT-1:0]      drv,
    input  logic                 obs,
    output logic                 busy,
    output logic                 done,
    output logic [EW-1:0]        err_cnt
`ifdef BUS_TERM_STIM_MISMATCH_LOG_EN
    ,
    output logic                 first_err_vld,
    output logic [NBIT-1:0]      first_err_code,
    output logic [7:0]           first_err_idx
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, APPLY} state_t;

    typedef struct packed {
        logic [NBIT-1:0] code;
        logic            exp;
        logic [HW-1:0]   hold;
    } entry_t;

    state_t        state, next_state;
    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [HW-1:0] cnt;
    logic          cur_exp;
    logic          win_end, mismatch;

    // Extra pointer bit tells a full FIFO apart from an empty one.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s.s_ready = !full;
    assign push      = s.s_valid && !full && !clr;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign busy      = (state == APPLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        if (clr) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (!empty) next_state = APPLY;
                APPLY:   if (cnt == '0 && empty) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        win_end  = !clr && (state == APPLY) && (cnt == '0);
        pop      = !clr && !empty && ((state == IDLE) || win_end);
        mismatch = win_end && (obs != cur_exp);
    end

    // NOTE: entry storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{code: s.s_code, exp: s.s_exp, hold: s.s_hold};
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv     <= IDLE_CODE;
            cnt     <= '0;
            cur_exp <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
        end else if (clr) begin
            drv     <= IDLE_CODE;
            cnt     <= '0;
            cur_exp <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
        end else begin
            done <= win_end && empty;
            if (pop) begin
                drv     <= head.code;
                cnt     <= head.hold;
                cur_exp <= head.exp;
            end else if (win_end) begin
                drv <= IDLE_CODE;
            end else if (state == APPLY) begin
                cnt <= cnt - HW'(1);
            end
            if (mismatch && err_cnt != '1) err_cnt <= err_cnt + EW'(1);
        end
    end

`ifdef BUS_TERM_STIM_MISMATCH_LOG_EN
    logic [7:0] win_idx;

    // drv still holds the code of the window being closed when the mismatch is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_idx        <= '0;
            first_err_vld  <= 1'b0;
            first_err_code <= '0;
            first_err_idx  <= '0;
        end else if (clr) begin
            win_idx        <= '0;
            first_err_vld  <= 1'b0;
            first_err_code <= '0;
            first_err_idx  <= '0;
        end else begin
            if (win_end) win_idx <= win_idx + 8'd1;
            if (mismatch && !first_err_vld) begin
                first_err_vld  <= 1'b1;
                first_err_code <= drv;
                first_err_idx  <= win_idx;
            end
        end
    end
`endif
endmodule
